// File: rtl/bmf_h_decoder_seq.sv
// Sequential Boolean-matrix-factorization decompressor.
// A K-bit compressed vector selects rows of a runtime-loaded K x M basis
// matrix H. The selected rows are folded into an M-bit result one row per
// cycle. Each output column combines with OR or with XOR, chosen by a
// per-column mask. Input and output use valid/ready handshakes, and only
// one vector is in flight at a time.
module bmf_h_decoder_seq #(
    parameter int K  = 7,
    parameter int M  = 9,
    parameter int RW = $clog2(K)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [RW-1:0] cfg_row,
    input  logic [M-1:0]  cfg_data,
    input  logic          cfg_mask_we,
    output logic          cfg_busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [K-1:0]  in_k,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_po
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    // Row index of the last basis row, and the exclusive bound for cfg_row.
    // The bound is one bit wider than cfg_row so that K = 2**RW still compares correctly.
    localparam logic [RW-1:0] LAST_ROW = RW'(K - 1);
    localparam logic [RW:0]   ROW_LIM  = (RW + 1)'(K);

    state_t         state_q;
    logic [M-1:0]   h_q [K];
    logic [M-1:0]   mask_q;
    logic [M-1:0]   acc_q;
    logic [M-1:0]   acc_d;
    logic [M-1:0]   out_po_q;
    logic [K-1:0]   k_q;
    logic [RW-1:0]  cnt_q;
    logic           out_valid_q;
    logic [M-1:0]   row_sel;
    logic           accept;
    logic           cfg_ok;

    // in_ready is held low while reset is asserted, so no vector is taken during reset.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    // Configuration is applied only while idle. A same-cycle accept takes priority,
    // so H and the mask cannot change under a running computation.
    assign cfg_ok    = (state_q == IDLE) && !accept;
    assign cfg_busy  = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_po    = out_po_q;

    // Fold the current H row into the accumulator: XOR in masked columns, OR elsewhere.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        row_sel = h_q[cnt_q];
        acc_d   = acc_q;
        if (k_q[cnt_q]) begin
            acc_d = (mask_q & (acc_q ^ row_sel)) | (~mask_q & (acc_q | row_sel));
        end
    end

    // Control FSM, configuration storage and the registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: H is cleared on reset on purpose; software must reprogram it after a reset.
            for (int r = 0; r < K; r++) begin
                h_q[r] <= '0;
            end
            mask_q      <= '0;
            acc_q       <= '0;
            out_po_q    <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
        end else begin
            // NOTE: non-blocking assignments keep every register update tied to this edge.
            if (cfg_ok) begin
                if (cfg_we && ({1'b0, cfg_row} < ROW_LIM)) begin
                    h_q[cfg_row] <= cfg_data;
                end
                if (cfg_mask_we) begin
                    mask_q <= cfg_data;
                end
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        k_q     <= in_k;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    // The counter returns to 0 through the state change; it never wraps by arithmetic.
                    if (cnt_q == LAST_ROW) begin
                        out_po_q    <= acc_d;
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + RW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
